dl11_fifo_regs: RTL and testbench

// Next-generation DL11 console/serial register block for the pdp11 iopage.

---
 rtl/dl11_fifo_regs.sv | 163 ++++++++++++++++
 tb/tb_dl11_fifo_regs.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl11_fifo_regs.sv
// DL11 console register block with RX/TX byte FIFOs, sticky overrun, maintenance
// loopback and acknowledge-based interrupt arbitration (RX before TX).
module dl11_fifo_regs #(
    parameter logic [12:0] BASE_ADDR = 13'o17560,
    parameter logic [7:0]  VECTOR    = 8'o60,
    parameter int          RX_LOG2   = 4,
    parameter int          TX_LOG2   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] iopage_addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        decode,
    input  logic        iopage_rd,
    input  logic        iopage_wr,
    input  logic        iopage_byte_op,
    output logic        interrupt,
    input  logic        interrupt_ack,
    output logic [7:0]  vector,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        tx_req,
    output logic [7:0]  tx_byte,
    input  logic        tx_ack
);
    localparam int         RX_DEPTH  = 1 << RX_LOG2;
    localparam int         TX_DEPTH  = 1 << TX_LOG2;
    localparam logic [7:0] TX_VECTOR = VECTOR + 8'd4;

    logic [7:0]         rx_mem [RX_DEPTH];
    logic [RX_LOG2-1:0] rx_wptr, rx_rptr;
    logic [RX_LOG2:0]   rx_count;
    logic [7:0]         tx_mem [TX_DEPTH];
    logic [TX_LOG2-1:0] tx_wptr, tx_rptr;
    logic [TX_LOG2:0]   tx_count;

    logic rie, xie, maint, ovr;
    logic rx_cond_q, tx_cond_q, rx_pend, tx_pend;

    logic [1:0]  reg_sel;
    logic        odd, wr_en, rcsr_wr, xcsr_wr, xbuf_wr, rbuf_rd;
    logic        rx_empty, rx_full, tx_empty, tx_full;
    logic [7:0]  rx_head, tx_head, rx_push_data;
    logic        rx_push, rx_pop, tx_push, tx_pop, loop_move, ovr_set;
    logic        rx_cond, tx_cond, rx_granted, tx_granted;
    logic [15:0] reg_word;
    logic        unused_bits;

    assign unused_bits = ^data_in[15:8];

    assign decode  = iopage_addr[12:3] == BASE_ADDR[12:3];
    assign reg_sel = iopage_addr[2:1];
    assign odd     = iopage_addr[0];
    assign wr_en   = decode && iopage_wr && !(iopage_byte_op && odd);
    assign rcsr_wr = wr_en && reg_sel == 2'd0;
    assign xcsr_wr = wr_en && reg_sel == 2'd2;
    assign xbuf_wr = wr_en && reg_sel == 2'd3;
    assign rbuf_rd = decode && iopage_rd && reg_sel == 2'd1 && !odd;

    assign rx_empty = rx_count == '0;
    assign rx_full  = rx_count[RX_LOG2];
    assign tx_empty = tx_count == '0;
    assign tx_full  = tx_count[TX_LOG2];
    assign rx_head  = rx_empty ? 8'd0 : rx_mem[rx_rptr];
    assign tx_head  = tx_empty ? 8'd0 : tx_mem[tx_rptr];

    // Loopback owns the RX write port in maintenance mode; the uart is ignored.
    assign loop_move    = maint && !tx_empty && !rx_full;
    assign rx_pop       = rbuf_rd && !rx_empty;
    assign rx_push      = maint ? loop_move : (rx_valid && (!rx_full || rx_pop));
    assign rx_push_data = maint ? tx_head : rx_byte;
    assign ovr_set      = !maint && rx_valid && rx_full && !rx_pop;

    assign tx_req  = !maint && !tx_empty;
    assign tx_byte = tx_head;
    assign tx_push = xbuf_wr && !tx_full;
    assign tx_pop  = loop_move || (tx_req && tx_ack);

    assign rx_cond    = rie && !rx_empty;
    assign tx_cond    = xie && !tx_full;
    assign rx_granted = interrupt_ack && interrupt && vector == VECTOR;
    assign tx_granted = interrupt_ack && interrupt && vector == TX_VECTOR;

    always_comb begin
        reg_word = '0;
        case (reg_sel)
            2'd0:    reg_word = {ovr, ovr, 6'b0, !rx_empty, rie, 6'b0};
            2'd1:    reg_word = {ovr, ovr, 6'b0, rx_head};
            2'd2:    reg_word = {8'b0, !tx_full, xie, 3'b0, maint, 2'b0};
            default: reg_word = '0;
        endcase
        data_out = '0;
        if (decode && iopage_rd)
            data_out = (iopage_byte_op && odd) ? {8'b0, reg_word[15:8]} : reg_word;
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_push_data;
        if (tx_push) tx_mem[tx_wptr] <= data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + RX_LOG2'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + RX_LOG2'(1);
            if (rx_push && !rx_pop)
                rx_count <= rx_count + (RX_LOG2+1)'(1);
            else if (!rx_push && rx_pop)
                rx_count <= rx_count - (RX_LOG2+1)'(1);
            if (tx_push) tx_wptr <= tx_wptr + TX_LOG2'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + TX_LOG2'(1);
            if (tx_push && !tx_pop)
                tx_count <= tx_count + (TX_LOG2+1)'(1);
            else if (!tx_push && tx_pop)
                tx_count <= tx_count - (TX_LOG2+1)'(1);
        end
    end

    // A pending latch arms only on a rising condition, so an acked request
    // stays quiet until its condition falls and rises again.
    always_ff @(posedge clk) begin
        if (reset) begin
            rie       <= 1'b0;
            xie       <= 1'b0;
            maint     <= 1'b0;
            ovr       <= 1'b0;
            rx_cond_q <= 1'b0;
            tx_cond_q <= 1'b0;
            rx_pend   <= 1'b0;
            tx_pend   <= 1'b0;
            interrupt <= 1'b0;
            vector    <= 8'd0;
        end else begin
            if (rcsr_wr) rie <= data_in[6];
            if (xcsr_wr) begin
                xie   <= data_in[6];
                maint <= data_in[2];
            end
            if (rbuf_rd)      ovr <= 1'b0;
            else if (ovr_set) ovr <= 1'b1;

            rx_cond_q <= rx_cond;
            tx_cond_q <= tx_cond;
            if (!rx_cond)        rx_pend <= 1'b0;
            else if (!rx_cond_q) rx_pend <= 1'b1;
            else if (rx_granted) rx_pend <= 1'b0;
            if (!tx_cond)        tx_pend <= 1'b0;
            else if (!tx_cond_q) tx_pend <= 1'b1;
            else if (tx_granted) tx_pend <= 1'b0;

            interrupt <= rx_pend || tx_pend;
            vector    <= rx_pend ? VECTOR : (tx_pend ? TX_VECTOR : 8'd0);
        end
    end
endmodule

// File: tb/tb_dl11_fifo_regs.sv
// Directed testbench for dl11_fifo_regs: register reads, FIFO ordering,
// overrun, loopback, interrupt arbitration and byte-lane reads.
module tb_dl11_fifo_regs;
    localparam logic [12:0] RCSR = 13'o17560;
    localparam logic [12:0] RBUF = 13'o17562;
    localparam logic [12:0] XCSR = 13'o17564;
    localparam logic [12:0] XBUF = 13'o17566;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] iopage_addr = '0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        decode;
    logic        iopage_rd = 1'b0;
    logic        iopage_wr = 1'b0;
    logic        iopage_byte_op = 1'b0;
    logic        interrupt;
    logic        interrupt_ack = 1'b0;
    logic [7:0]  vector;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        tx_req;
    logic [7:0]  tx_byte;
    logic        tx_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    dl11_fifo_regs dut (
        .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
        .data_out(data_out), .decode(decode), .iopage_rd(iopage_rd),
        .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack), .vector(vector),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_req(tx_req),
        .tx_byte(tx_byte), .tx_ack(tx_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [12:0] addr, input logic [15:0] d, input logic bop);
        iopage_addr = addr;
        data_in = d;
        iopage_byte_op = bop;
        iopage_wr = 1'b1;
        tick();
        iopage_wr = 1'b0;
        iopage_byte_op = 1'b0;
    endtask

    task automatic bus_read(input logic [12:0] addr, input logic bop, output logic [15:0] d);
        iopage_addr = addr;
        iopage_byte_op = bop;
        iopage_rd = 1'b1;
        #1;
        d = data_out;
        tick();
        iopage_rd = 1'b0;
        iopage_byte_op = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({interrupt, vector, tx_req} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got irq=%b vec=%o req=%b, expected all 0", interrupt, vector, tx_req);
        end
        bus_read(RCSR, 1'b0, d);
        checks++;
        if (d !== 16'o0) begin
            errors++;
            $display("[TB] FAIL reset_rcsr: got %o expected 0", d);
        end
        bus_read(XCSR, 1'b0, d);
        checks++;
        if (d !== 16'o200) begin
            errors++;
            $display("[TB] FAIL reset_xcsr: got %o expected 200", d);
        end
        iopage_addr = 13'o17570;
        #1;
        checks++;
        if (decode !== 1'b0) begin
            errors++;
            $display("[TB] FAIL decode_miss: got %b expected 0", decode);
        end
        iopage_addr = RCSR + 13'd5;
        #1;
        checks++;
        if (decode !== 1'b1) begin
            errors++;
            $display("[TB] FAIL decode_hit: got %b expected 1", decode);
        end
    endtask

    task automatic test_tx_drain();
        logic [7:0]  pat [3];
        logic [15:0] d;
        pat = '{8'h11, 8'h22, 8'h33};
        tx_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_write(XBUF, {8'hA5, pat[i]}, 1'b0);
            checks++;
            if ({tx_req, tx_byte} !== {1'b1, pat[i]}) begin
                errors++;
                $display("[TB] FAIL tx_drain_%0d: got req=%b byte=%h expected req=1 byte=%h", i, tx_req, tx_byte, pat[i]);
            end
        end
        tick();
        checks++;
        if (tx_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tx_drain_done: got req=%b expected 0", tx_req);
        end
        bus_read(XCSR, 1'b0, d);
        checks++;
        if (d !== 16'o200) begin
            errors++;
            $display("[TB] FAIL tx_drain_ready: got %o expected 200", d);
        end
        tx_ack = 1'b0;
    endtask

    task automatic test_tx_full();
        logic [15:0] d;
        for (int i = 0; i < 17; i++) bus_write(XBUF, 16'(i + 1), 1'b0);
        bus_read(XCSR, 1'b0, d);
        checks++;
        if (d !== 16'o0) begin
            errors++;
            $display("[TB] FAIL tx_full_ready: got %o expected 0", d);
        end
        tx_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({tx_req, tx_byte} !== {1'b1, 8'(i + 1)}) begin
                errors++;
                $display("[TB] FAIL tx_full_order_%0d: got req=%b byte=%h expected req=1 byte=%h", i, tx_req, tx_byte, 8'(i + 1));
            end
            tick();
        end
        checks++;
        if (tx_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tx_full_drop: got req=%b expected 0", tx_req);
        end
        tx_ack = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        bus_write(XBUF, 16'h0044, 1'b0);
        bus_write(XBUF, 16'h0055, 1'b0);
        checks++;
        if (tx_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_pre: got req=%b expected 1", tx_req);
        end
        tx_ack = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (tx_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_req: got req=%b expected 0", tx_req);
        end
        tick();
        checks++;
        if (tx_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_resend: got req=%b expected 0", tx_req);
        end
        tx_ack = 1'b0;
    endtask

    task automatic test_rx_overrun();
        logic [15:0] d;
        logic [15:0] exp;
        for (int i = 0; i < 17; i++) rx_pulse(8'(i + 1));
        bus_read(RCSR, 1'b0, d);
        checks++;
        if (d !== 16'o140200) begin
            errors++;
            $display("[TB] FAIL rx_ovr_rcsr: got %o expected 140200", d);
        end
        for (int i = 0; i < 16; i++) begin
            bus_read(RBUF, 1'b0, d);
            exp = {(i == 0) ? 2'b11 : 2'b00, 6'b0, 8'(i + 1)};
            checks++;
            if (d !== exp) begin
                errors++;
                $display("[TB] FAIL rx_ovr_rbuf_%0d: got %h expected %h", i, d, exp);
            end
        end
        bus_read(RCSR, 1'b0, d);
        checks++;
        if (d !== 16'o0) begin
            errors++;
            $display("[TB] FAIL rx_ovr_after: got %o expected 0", d);
        end
        bus_read(RBUF, 1'b0, d);
        checks++;
        if (d !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL rx_empty_read: got %h expected 0000", d);
        end
    endtask

    task automatic test_rx_interrupt();
        logic [15:0] d;
        bus_write(RCSR, 16'o100, 1'b0);
        rx_pulse(8'h5A);
        tick();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_irq_early: got %b expected 0", interrupt);
        end
        tick();
        checks++;
        if ({interrupt, vector} !== {1'b1, 8'o60}) begin
            errors++;
            $display("[TB] FAIL rx_irq_raise: got irq=%b vec=%o expected irq=1 vec=60", interrupt, vector);
        end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (interrupt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rx_irq_acked: got %b expected 0", interrupt);
        end
        bus_read(RBUF, 1'b0, d);
        checks++;
        if (d !== 16'h005A) begin
            errors++;
            $display("[TB] FAIL rx_irq_data: got %h expected 005a", d);
        end
        rx_pulse(8'h6B);
        tick();
        tick();
        checks++;
        if ({interrupt, vector} !== {1'b1, 8'o60}) begin
            errors++;
            $display("[TB] FAIL rx_irq_rearm: got irq=%b vec=%o expected irq=1 vec=60", interrupt, vector);
        end
    endtask

    task automatic test_priority();
        bus_write(XCSR, 16'o100, 1'b0);
        tick();
        tick();
        checks++;
        if ({interrupt, vector} !== {1'b1, 8'o64}) begin
            errors++;
            $display("[TB] FAIL tx_irq_alone: got irq=%b vec=%o expected irq=1 vec=64", interrupt, vector);
        end
        do_reset();
        bus_write(RCSR, 16'o100, 1'b0);
        iopage_addr = XCSR;
        data_in = 16'o100;
        iopage_wr = 1'b1;
        rx_valid = 1'b1;
        rx_byte = 8'h01;
        tick();
        iopage_wr = 1'b0;
        rx_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({interrupt, vector} !== {1'b1, 8'o60}) begin
            errors++;
            $display("[TB] FAIL prio_rx_first: got irq=%b vec=%o expected irq=1 vec=60", interrupt, vector);
        end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        checks++;
        if ({interrupt, vector} !== {1'b1, 8'o64}) begin
            errors++;
            $display("[TB] FAIL prio_tx_second: got irq=%b vec=%o expected irq=1 vec=64", interrupt, vector);
        end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        checks++;
        if ({interrupt, vector} !== 9'd0) begin
            errors++;
            $display("[TB] FAIL prio_idle: got irq=%b vec=%o expected irq=0 vec=0", interrupt, vector);
        end
    endtask

    task automatic test_maint();
        logic [15:0] d;
        bus_write(XCSR, 16'o4, 1'b0);
        bus_write(XBUF, 16'o101, 1'b0);
        bus_write(XBUF, 16'o102, 1'b0);
        checks++;
        if (tx_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL maint_txreq: got %b expected 0", tx_req);
        end
        rx_pulse(8'h77);
        tick();
        bus_read(XCSR, 1'b0, d);
        checks++;
        if (d !== 16'o204) begin
            errors++;
            $display("[TB] FAIL maint_xcsr: got %o expected 204", d);
        end
        bus_read(RBUF, 1'b0, d);
        checks++;
        if (d !== 16'o101) begin
            errors++;
            $display("[TB] FAIL maint_rbuf_0: got %o expected 101", d);
        end
        bus_read(RBUF, 1'b0, d);
        checks++;
        if (d !== 16'o102) begin
            errors++;
            $display("[TB] FAIL maint_rbuf_1: got %o expected 102", d);
        end
        bus_read(RCSR, 1'b0, d);
        checks++;
        if (d !== 16'o0) begin
            errors++;
            $display("[TB] FAIL maint_rx_ignored: got %o expected 0", d);
        end
    endtask

    task automatic test_byte_read();
        logic [15:0] d;
        for (int i = 0; i < 17; i++) rx_pulse(8'(i + 1));
        bus_read(RCSR + 13'd1, 1'b1, d);
        checks++;
        if (d !== 16'o300) begin
            errors++;
            $display("[TB] FAIL byte_rcsr_hi: got %o expected 300", d);
        end
        bus_read(RBUF + 13'd1, 1'b1, d);
        checks++;
        if (d !== 16'o300) begin
            errors++;
            $display("[TB] FAIL byte_rbuf_hi: got %o expected 300", d);
        end
        bus_read(RBUF, 1'b0, d);
        checks++;
        if (d !== 16'hC001) begin
            errors++;
            $display("[TB] FAIL byte_no_pop: got %h expected c001", d);
        end
        bus_read(RBUF, 1'b0, d);
        checks++;
        if (d !== 16'h0002) begin
            errors++;
            $display("[TB] FAIL byte_next_pop: got %h expected 0002", d);
        end
    endtask

    initial begin
        test_reset();
        do_reset();
        test_tx_drain();
        do_reset();
        test_tx_full();
        do_reset();
        test_reset_mid_transfer();
        do_reset();
        test_rx_overrun();
        do_reset();
        test_rx_interrupt();
        do_reset();
        test_priority();
        do_reset();
        test_maint();
        do_reset();
        test_byte_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
